rv_multicycle_ctrl: RTL and testbench
=====================================

RV_MULTICYCLE_CTRL -- requirements
Module: rv_multicycle_ctrl

Interface
REQ-001 Parameter EN_MUL, default 0, meaning 1 enables RV32M multiply dispatch (opc 0110011 with f7 0000001); 0 traps it.
REQ-002 Parameter MEM_HANDSHAKE, default 1, meaning 1 honours mem_ready; 0 treats mem_ready as constant 1.
REQ-003 clk  input  1  rising-edge clock; single clock domain.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 opc, f3, f7  input  7, 3, 7  opcode, funct3, funct7 from the instruction register.
REQ-006 zero, neg  input  1, 1  ALU flags.
REQ-007 mem_ready, mul_done  input  1, 1  memory access complete; multiplier result valid.
REQ-008 PCWrite, adrSrc, memRead, memWrite, IRWrite, regWrite, mulStart  output  1 each  datapath strobes.
REQ-009 resultSrc  output  3  000 ALUOut, 001 data reg, 010 ALU result, 011 immediate, 100 multiplier.
REQ-010 ALUSrcA, ALUSrcB  output  2, 2  A: 00 PC, 01 oldPC, 10 rs1. B: 00 rs2, 01 imm, 10 const 4.
REQ-011 ALUControl  output  4  0000 add, 0001 sub, 0010 and, 0011 or, 0100 xor, 0101 slt, 0110 sltu, 0111 sll, 1000 srl, 1001 sra.
REQ-012 immSrc  output  3  000 I, 001 S, 010 B, 011 J, 100 U.
REQ-013 illegal  output  1  sticky trap flag; state  output  4  current FSM state, for debug.

Function
REQ-014 Moore FSM; all outputs except illegal and mulStart decode combinationally from state, f3, f7, zero and neg; unlisted strobes are 0 and unlisted selects are 0.
REQ-015 States: FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JAL, JALR1, JALR2, LUI, MUL_WAIT, TRAP.
REQ-016 FETCH outputs: memRead=1, adrSrc=0, ALUSrcA=00, ALUSrcB=10, add, resultSrc=010. IRWrite=PCWrite=mem_ready. Next state is DECODE on mem_ready, otherwise stay.
REQ-017 DECODE outputs: ALUSrcA=01, ALUSrcB=01, add; immSrc=011 if opc=1101111, else 010.
REQ-018 DECODE dispatch on opc:
  - 0110011: EXEC_R, or MUL_WAIT if f7=0000001 and EN_MUL=1.
  - 0010011: EXEC_I.
  - 0000011 or 0100011: MEM_ADR.
  - 1100011: BRANCH.
  - 1101111: JAL.
  - 1100111: JALR1.
  - 0110111: LUI.
  - Any other opcode: TRAP.
REQ-019 ALU decode, f3 to ALUControl: 000 add (sub if EXEC_R and f7[5]), 111 and, 110 or, 100 xor, 010 slt, 011 sltu, 001 sll, 101 srl/sra by f7[5].
  - EXEC_R: ALUSrcA=10, ALUSrcB=00.
  - EXEC_I: ALUSrcA=10, ALUSrcB=01, immSrc=000.
  - Both proceed to ALU_WB.
REQ-020 ALU_WB: regWrite=1, resultSrc=000; next FETCH.
REQ-021 MEM_ADR: ALUSrcA=10, ALUSrcB=01, add; immSrc=000 for load, 001 for store. Next MEM_RD for load, MEM_WR for store.
REQ-022 MEM_RD: adrSrc=1, memRead=1; hold until mem_ready, then MEM_WB.
REQ-023 MEM_WB: regWrite=1, resultSrc=001; next FETCH.
REQ-024 MEM_WR: adrSrc=1, memWrite=1; hold until mem_ready, then FETCH.
REQ-025 BRANCH: ALUSrcA=10, ALUSrcB=00, sub, resultSrc=000.
  - PCWrite by f3: 000 zero, 001 !zero, 100 neg, 101 !neg; next FETCH.
  - Any other f3: PCWrite=0, next TRAP.
REQ-026 JAL: PCWrite=1, resultSrc=000, ALUSrcA=01, ALUSrcB=10, add; next ALU_WB.
REQ-027 JALR1: ALUSrcA=10, ALUSrcB=01, immSrc=000, add; next JALR2. JALR2 has the same outputs as JAL; next ALU_WB.
REQ-028 LUI: immSrc=100, resultSrc=011, regWrite=1; next FETCH.
REQ-029 MUL_WAIT:
  - mulStart is a registered 1-cycle pulse on the first MUL_WAIT cycle only.
  - Hold until mul_done; in the mul_done cycle, regWrite=1 and resultSrc=100; next FETCH.
  - mul_done arriving in the first cycle is accepted.
REQ-030 TRAP: all strobes 0; illegal is set on entry and held; the FSM stays in TRAP until rst.
REQ-031 Memory stalls are unbounded; no strobe other than memRead/memWrite/adrSrc is asserted in stalled cycles.

Reset
REQ-032 rst asynchronously forces state=FETCH, illegal=0, mulStart=0, in any state including mid-stall and TRAP.
REQ-033 While rst is high, outputs show FETCH decode with IRWrite=PCWrite forced 0; the first active edge after release performs FETCH.

Verification
REQ-034 add x3,x1,x2 (opc 0110011, f3 000, f7 0) with mem_ready=1 -> FETCH, DECODE, EXEC_R (ALUControl 0000), ALU_WB (regWrite=1); 4 cycles.
REQ-035 lw with mem_ready low 3 cycles in MEM_RD -> memRead=1, adrSrc=1 held 4 cycles, then MEM_WB with resultSrc=001, regWrite=1.
REQ-036 bne with zero=0 -> PCWrite=1 in BRANCH. bne with zero=1 -> PCWrite=0. f3=010 -> TRAP, illegal=1 until rst.
REQ-037 EN_MUL=1, mul f7=0000001, mul_done after 5 cycles -> mulStart high exactly 1 cycle, regWrite=1 with resultSrc=100 once. EN_MUL=0 -> TRAP.
REQ-038 jalr -> JALR1 (immSrc 000), JALR2 (PCWrite=1), ALU_WB (regWrite=1).
REQ-039 rst asserted mid MEM_WR stall -> state=FETCH immediately without a clock edge; memWrite drops to 0 asynchronously.

Source files
------------

// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl: Moore control FSM for a multicycle RV32I datapath with optional RV32M multiply dispatch.
// Strobes decode from the current state; illegal and mulStart are registered.
module rv_multicycle_ctrl #(
    parameter logic EN_MUL        = 1'b0,
    parameter logic MEM_HANDSHAKE = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opc,
    input  logic [2:0] f3,
    input  logic [6:0] f7,
    input  logic       zero,
    input  logic       neg,
    input  logic       mem_ready,
    input  logic       mul_done,
    output logic       PCWrite,
    output logic       adrSrc,
    output logic       memRead,
    output logic       memWrite,
    output logic       IRWrite,
    output logic       regWrite,
    output logic       mulStart,
    output logic [2:0] resultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [3:0] ALUControl,
    output logic [2:0] immSrc,
    output logic       illegal,
    output logic [3:0] state
);
    typedef enum logic [3:0] {
        FETCH, DECODE, EXEC_R, EXEC_I, ALU_WB, MEM_ADR, MEM_RD, MEM_WB,
        MEM_WR, BRANCH, JAL, JALR1, JALR2, LUI, MUL_WAIT, TRAP
    } state_t;

    state_t     state_q, state_d;
    logic       illegal_q, illegal_d;
    logic       mul_start_q, mul_start_d;
    logic       mr, is_ld;
    logic [3:0] alu_fn;

    assign mr       = MEM_HANDSHAKE ? mem_ready : 1'b1;
    assign is_ld    = opc == 7'b0000011;
    assign state    = state_q;
    assign illegal  = illegal_q;
    assign mulStart = mul_start_q;

    // f7[5] selects sub only for register-register ops; shifts use it in both forms
    always_comb begin
        alu_fn = 4'b0000;
        case (f3)
            3'b000: alu_fn = (state_q == EXEC_R && f7[5]) ? 4'b0001 : 4'b0000;
            3'b111: alu_fn = 4'b0010;
            3'b110: alu_fn = 4'b0011;
            3'b100: alu_fn = 4'b0100;
            3'b010: alu_fn = 4'b0101;
            3'b011: alu_fn = 4'b0110;
            3'b001: alu_fn = 4'b0111;
            default: alu_fn = f7[5] ? 4'b1001 : 4'b1000;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        PCWrite    = 1'b0;
        adrSrc     = 1'b0;
        memRead    = 1'b0;
        memWrite   = 1'b0;
        IRWrite    = 1'b0;
        regWrite   = 1'b0;
        resultSrc  = 3'b000;
        ALUSrcA    = 2'b00;
        ALUSrcB    = 2'b00;
        ALUControl = 4'b0000;
        immSrc     = 3'b000;
        case (state_q)
            FETCH: begin
                memRead   = 1'b1;
                ALUSrcB   = 2'b10;
                resultSrc = 3'b010;
                IRWrite   = mr & ~rst;
                PCWrite   = mr & ~rst;
                state_d   = mr ? DECODE : FETCH;
            end
            DECODE: begin
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b01;
                immSrc  = (opc == 7'b1101111) ? 3'b011 : 3'b010;
                case (opc)
                    7'b0110011: state_d = (f7 != 7'b0000001) ? EXEC_R : (EN_MUL ? MUL_WAIT : TRAP);
                    7'b0010011: state_d = EXEC_I;
                    7'b0000011, 7'b0100011: state_d = MEM_ADR;
                    7'b1100011: state_d = BRANCH;
                    7'b1101111: state_d = JAL;
                    7'b1100111: state_d = JALR1;
                    7'b0110111: state_d = LUI;
                    default: state_d = TRAP;
                endcase
            end
            EXEC_R: begin
                ALUSrcA    = 2'b10;
                ALUControl = alu_fn;
                state_d    = ALU_WB;
            end
            EXEC_I: begin
                ALUSrcA    = 2'b10;
                ALUSrcB    = 2'b01;
                ALUControl = alu_fn;
                state_d    = ALU_WB;
            end
            ALU_WB: begin
                regWrite = 1'b1;
                state_d  = FETCH;
            end
            MEM_ADR: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                immSrc  = is_ld ? 3'b000 : 3'b001;
                state_d = is_ld ? MEM_RD : MEM_WR;
            end
            MEM_RD: begin
                adrSrc  = 1'b1;
                memRead = 1'b1;
                state_d = mr ? MEM_WB : MEM_RD;
            end
            MEM_WB: begin
                regWrite  = 1'b1;
                resultSrc = 3'b001;
                state_d   = FETCH;
            end
            MEM_WR: begin
                adrSrc   = 1'b1;
                memWrite = 1'b1;
                state_d  = mr ? FETCH : MEM_WR;
            end
            BRANCH: begin
                ALUSrcA    = 2'b10;
                ALUControl = 4'b0001;
                state_d    = FETCH;
                case (f3)
                    3'b000: PCWrite = zero;
                    3'b001: PCWrite = ~zero;
                    3'b100: PCWrite = neg;
                    3'b101: PCWrite = ~neg;
                    default: state_d = TRAP;
                endcase
            end
            JAL, JALR2: begin
                PCWrite = 1'b1;
                ALUSrcA = 2'b01;
                ALUSrcB = 2'b10;
                state_d = ALU_WB;
            end
            JALR1: begin
                ALUSrcA = 2'b10;
                ALUSrcB = 2'b01;
                state_d = JALR2;
            end
            LUI: begin
                immSrc    = 3'b100;
                resultSrc = 3'b011;
                regWrite  = 1'b1;
                state_d   = FETCH;
            end
            MUL_WAIT: begin
                regWrite  = mul_done;
                resultSrc = mul_done ? 3'b100 : 3'b000;
                state_d   = mul_done ? FETCH : MUL_WAIT;
            end
            default: state_d = TRAP;
        endcase
        illegal_d   = illegal_q | (state_d == TRAP);
        mul_start_d = (state_d == MUL_WAIT) & (state_q != MUL_WAIT);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= FETCH;
            illegal_q   <= 1'b0;
            mul_start_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            illegal_q   <= illegal_d;
            mul_start_q <= mul_start_d;
        end
    end
endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb_rv_multicycle_ctrl: directed vectors with a queued scoreboard for rv_multicycle_ctrl.
// Main DUT has multiply enabled; a second copy without it must trap on mul.
module tb_rv_multicycle_ctrl;
    logic       clk = 1'b0, rst = 1'b1;
    logic [6:0] opc = 7'd0, f7 = 7'd0, n_opc = 7'd0, n_f7 = 7'd0;
    logic [2:0] f3 = 3'd0, n_f3 = 3'd0;
    logic       zero = 1'b0, neg = 1'b0, mem_ready = 1'b1, mul_done = 1'b0;

    logic       PCWrite, adrSrc, memRead, memWrite, IRWrite, regWrite, mulStart, illegal;
    logic [2:0] resultSrc, immSrc;
    logic [1:0] ALUSrcA, ALUSrcB;
    logic [3:0] ALUControl, state;

    logic       d0_pcw, d0_adr, d0_mrd, d0_mwr, d0_irw, d0_rgw, d0_mst, d0_ill;
    logic [2:0] d0_rs, d0_imm;
    logic [1:0] d0_sa, d0_sb;
    logic [3:0] d0_alu, d0_state;

    rv_multicycle_ctrl #(.EN_MUL(1'b1), .MEM_HANDSHAKE(1'b1)) dut (
        .clk(clk), .rst(rst), .opc(opc), .f3(f3), .f7(f7), .zero(zero), .neg(neg),
        .mem_ready(mem_ready), .mul_done(mul_done), .PCWrite(PCWrite), .adrSrc(adrSrc),
        .memRead(memRead), .memWrite(memWrite), .IRWrite(IRWrite), .regWrite(regWrite),
        .mulStart(mulStart), .resultSrc(resultSrc), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .ALUControl(ALUControl), .immSrc(immSrc), .illegal(illegal), .state(state)
    );

    rv_multicycle_ctrl #(.EN_MUL(1'b0), .MEM_HANDSHAKE(1'b1)) dut0 (
        .clk(clk), .rst(rst), .opc(opc), .f3(f3), .f7(f7), .zero(zero), .neg(neg),
        .mem_ready(mem_ready), .mul_done(mul_done), .PCWrite(d0_pcw), .adrSrc(d0_adr),
        .memRead(d0_mrd), .memWrite(d0_mwr), .IRWrite(d0_irw), .regWrite(d0_rgw),
        .mulStart(d0_mst), .resultSrc(d0_rs), .ALUSrcA(d0_sa), .ALUSrcB(d0_sb),
        .ALUControl(d0_alu), .immSrc(d0_imm), .illegal(d0_ill), .state(d0_state)
    );

    always #5 clk = ~clk;

    typedef struct {
        string       nm;
        logic [25:0] v;
        logic        c0;
        logic [4:0]  v0;
    } exp_t;

    exp_t        q[$];
    exp_t        cur;
    int          n_vec = 0, n_bad = 0;
    logic [25:0] act;
    logic [4:0]  act0;

    assign act  = {state, PCWrite, adrSrc, memRead, memWrite, IRWrite, regWrite, mulStart,
                   resultSrc, ALUSrcA, ALUSrcB, ALUControl, immSrc, illegal};
    assign act0 = {d0_state, d0_ill};

    // Monitor samples mid-cycle, after the stimulus settled behind the rising edge
    always @(negedge clk) begin
        if (q.size() > 0) begin
            cur = q.pop_front();
            n_vec++;
            if (act !== cur.v) begin
                n_bad++;
                $display("FAIL %s: got %h want %h", cur.nm, act, cur.v);
            end
            if (cur.c0) begin
                n_vec++;
                if (act0 !== cur.v0) begin
                    n_bad++;
                    $display("FAIL %s (no-mul copy state/illegal): got %h want %h", cur.nm, act0, cur.v0);
                end
            end
        end
    end

    function automatic logic [25:0] o(input logic [3:0] st, input logic pcw, adr, mrd, mwr, irw, rgw, mst,
                                      input logic [2:0] rs, input logic [1:0] sa, sb,
                                      input logic [3:0] alu, input logic [2:0] imm, input logic ill);
        return {st, pcw, adr, mrd, mwr, irw, rgw, mst, rs, sa, sb, alu, imm, ill};
    endfunction

    function automatic logic [25:0] fe(input logic mr);
        return o(4'd0, mr, 0, 1, 0, mr, 0, 0, 3'b010, 2'b00, 2'b10, 4'd0, 3'b000, 0);
    endfunction

    function automatic logic [25:0] de(input logic [2:0] imm);
        return o(4'd1, 0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b01, 2'b01, 4'd0, imm, 0);
    endfunction

    function automatic logic [25:0] wb();
        return o(4'd4, 0, 0, 0, 0, 0, 1, 0, 3'b000, 2'b00, 2'b00, 4'd0, 3'b000, 0);
    endfunction

    function automatic logic [25:0] tr();
        return o(4'd15, 0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 4'd0, 3'b000, 1);
    endfunction

    task automatic ins(input logic [6:0] op, input logic [2:0] fn3, input logic [6:0] fn7);
        n_opc = op;
        n_f3  = fn3;
        n_f7  = fn7;
    endtask

    task automatic step(input string nm, input logic r, z, n, mr, md, input logic [25:0] e,
                        input logic c0 = 1'b0, input logic [4:0] e0 = 5'd0);
        exp_t x;
        @(posedge clk);
        #1;
        rst = r; zero = z; neg = n; mem_ready = mr; mul_done = md;
        opc = n_opc; f3 = n_f3; f7 = n_f7;
        x.nm = nm; x.v = e; x.c0 = c0; x.v0 = e0;
        q.push_back(x);
    endtask

    task automatic s(input string nm, input logic [25:0] e);
        step(nm, 0, 0, 0, 1, 0, e);
    endtask

    task automatic alu_instr(input logic [6:0] op, input logic [2:0] fn3, input logic [6:0] fn7, input logic [3:0] alu);
        logic r;
        r = op == 7'b0110011;
        ins(op, fn3, fn7);
        s("fetch", fe(1));
        s("decode", de(3'b010));
        s($sformatf("exec op=%b f3=%b f7=%b", op, fn3, fn7),
          o(r ? 4'd2 : 4'd3, 0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b10, r ? 2'b00 : 2'b01, alu, 3'b000, 0));
        s("alu_wb", wb());
    endtask

    // {opc, f3, f7, expected ALUControl}
    logic [20:0] alu_tab[13] = '{
        {7'b0110011, 3'b000, 7'h00, 4'd0}, {7'b0110011, 3'b000, 7'h20, 4'd1},
        {7'b0110011, 3'b111, 7'h00, 4'd2}, {7'b0110011, 3'b110, 7'h00, 4'd3},
        {7'b0110011, 3'b100, 7'h00, 4'd4}, {7'b0110011, 3'b010, 7'h00, 4'd5},
        {7'b0110011, 3'b011, 7'h00, 4'd6}, {7'b0110011, 3'b001, 7'h00, 4'd7},
        {7'b0110011, 3'b101, 7'h00, 4'd8}, {7'b0110011, 3'b101, 7'h20, 4'd9},
        {7'b0010011, 3'b000, 7'h20, 4'd0}, {7'b0010011, 3'b101, 7'h20, 4'd9},
        {7'b0010011, 3'b110, 7'h00, 4'd3}
    };

    // {f3, zero, neg, expected PCWrite}
    logic [5:0] br_tab[8] = '{
        {3'b001, 1'b0, 1'b0, 1'b1}, {3'b001, 1'b1, 1'b0, 1'b0},
        {3'b000, 1'b1, 1'b0, 1'b1}, {3'b000, 1'b0, 1'b0, 1'b0},
        {3'b100, 1'b0, 1'b1, 1'b1}, {3'b100, 1'b0, 1'b0, 1'b0},
        {3'b101, 1'b0, 1'b1, 1'b0}, {3'b101, 1'b0, 1'b0, 1'b1}
    };

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout want completion");
        $fatal(1);
    end

    initial begin
        logic [6:0] op, fn7;
        logic [2:0] fn3;
        logic [3:0] alu;
        logic       z, n, pcw;
        ins(7'b0110011, 3'b000, 7'h00);
        step("rst_hold", 1, 0, 0, 1, 0, fe(0));
        step("rst_release_stall", 0, 0, 0, 0, 0, fe(0));
        for (int i = 0; i < 13; i++) begin
            {op, fn3, fn7, alu} = alu_tab[i];
            alu_instr(op, fn3, fn7, alu);
        end
        // load with fetch stall and three memory stall cycles
        ins(7'b0000011, 3'b010, 7'h00);
        step("fetch_stall", 0, 0, 0, 0, 0, fe(0));
        s("fetch", fe(1));
        s("decode_lw", de(3'b010));
        s("mem_adr_lw", o(4'd5, 0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b10, 2'b01, 4'd0, 3'b000, 0));
        for (int i = 0; i < 3; i++)
            step("mem_rd_stall", 0, 0, 0, 0, 0, o(4'd6, 0, 1, 1, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 4'd0, 3'b000, 0));
        s("mem_rd_done", o(4'd6, 0, 1, 1, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 4'd0, 3'b000, 0));
        s("mem_wb", o(4'd7, 0, 0, 0, 0, 0, 1, 0, 3'b001, 2'b00, 2'b00, 4'd0, 3'b000, 0));
        ins(7'b0100011, 3'b010, 7'h00);
        s("fetch", fe(1));
        s("decode_sw", de(3'b010));
        s("mem_adr_sw", o(4'd5, 0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b10, 2'b01, 4'd0, 3'b001, 0));
        step("mem_wr_stall", 0, 0, 0, 0, 0, o(4'd8, 0, 1, 0, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 4'd0, 3'b000, 0));
        s("mem_wr_done", o(4'd8, 0, 1, 0, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 4'd0, 3'b000, 0));
        for (int i = 0; i < 8; i++) begin
            {fn3, z, n, pcw} = br_tab[i];
            ins(7'b1100011, fn3, 7'h00);
            s("fetch", fe(1));
            s("decode_br", de(3'b010));
            step($sformatf("branch f3=%b z=%b n=%b", fn3, z, n), 0, z, n, 1, 0,
                 o(4'd9, pcw, 0, 0, 0, 0, 0, 0, 3'b000, 2'b10, 2'b00, 4'd1, 3'b000, 0));
        end
        // unsupported branch condition traps until reset
        ins(7'b1100011, 3'b010, 7'h00);
        s("fetch", fe(1));
        s("decode_br", de(3'b010));
        step("branch_bad_f3", 0, 1, 1, 1, 0, o(4'd9, 0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b10, 2'b00, 4'd1, 3'b000, 0));
        s("trap_entry", tr());
        step("trap_hold", 0, 1, 1, 1, 1, tr());
        s("trap_hold2", tr());
        step("rst_from_trap", 1, 0, 0, 1, 0, fe(0));
        ins(7'b1101111, 3'b000, 7'h00);
        step("rst_release_stall", 0, 0, 0, 0, 0, fe(0));
        s("fetch", fe(1));
        s("decode_jal", de(3'b011));
        s("jal", o(4'd10, 1, 0, 0, 0, 0, 0, 0, 3'b000, 2'b01, 2'b10, 4'd0, 3'b000, 0));
        s("jal_wb", wb());
        ins(7'b1100111, 3'b000, 7'h00);
        s("fetch", fe(1));
        s("decode_jalr", de(3'b010));
        s("jalr1", o(4'd11, 0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b10, 2'b01, 4'd0, 3'b000, 0));
        s("jalr2", o(4'd12, 1, 0, 0, 0, 0, 0, 0, 3'b000, 2'b01, 2'b10, 4'd0, 3'b000, 0));
        s("jalr_wb", wb());
        ins(7'b0110111, 3'b000, 7'h00);
        s("fetch", fe(1));
        s("decode_lui", de(3'b010));
        s("lui", o(4'd13, 0, 0, 0, 0, 0, 1, 0, 3'b011, 2'b00, 2'b00, 4'd0, 3'b100, 0));
        // multiply: done after five waiting cycles; copy without RV32M traps
        ins(7'b0110011, 3'b000, 7'h01);
        step("fetch_mul", 0, 0, 0, 1, 0, fe(1), 1, {4'd0, 1'b0});
        step("decode_mul", 0, 0, 0, 1, 0, de(3'b010), 1, {4'd1, 1'b0});
        step("mul_first", 0, 0, 0, 1, 0, o(4'd14, 0, 0, 0, 0, 0, 0, 1, 3'b000, 2'b00, 2'b00, 4'd0, 3'b000, 0), 1, {4'd15, 1'b1});
        for (int i = 0; i < 4; i++)
            step("mul_wait", 0, 0, 0, 1, 0, o(4'd14, 0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b00, 2'b00, 4'd0, 3'b000, 0), 1, {4'd15, 1'b1});
        step("mul_done", 0, 0, 0, 1, 1, o(4'd14, 0, 0, 0, 0, 0, 1, 0, 3'b100, 2'b00, 2'b00, 4'd0, 3'b000, 0), 1, {4'd15, 1'b1});
        step("fetch_after_mul", 0, 0, 0, 1, 0, fe(1), 1, {4'd15, 1'b1});
        s("decode_mul2", de(3'b010));
        step("mul_done_first", 0, 0, 0, 1, 1, o(4'd14, 0, 0, 0, 0, 0, 1, 1, 3'b100, 2'b00, 2'b00, 4'd0, 3'b000, 0));
        ins(7'b0000000, 3'b000, 7'h00);
        s("fetch", fe(1));
        s("decode_bad_opc", de(3'b010));
        s("trap_bad_opc", tr());
        // reset asserted mid store stall must act without a clock edge
        step("rst_from_trap2", 1, 0, 0, 1, 0, fe(0));
        ins(7'b0100011, 3'b010, 7'h00);
        step("rst_release_stall", 0, 0, 0, 0, 0, fe(0));
        s("fetch", fe(1));
        s("decode_sw", de(3'b010));
        s("mem_adr_sw", o(4'd5, 0, 0, 0, 0, 0, 0, 0, 3'b000, 2'b10, 2'b01, 4'd0, 3'b001, 0));
        for (int i = 0; i < 2; i++)
            step("mem_wr_stall", 0, 0, 0, 0, 0, o(4'd8, 0, 1, 0, 1, 0, 0, 0, 3'b000, 2'b00, 2'b00, 4'd0, 3'b000, 0));
        step("rst_mid_mem_wr", 1, 0, 0, 0, 0, fe(0));
        s("fetch_after_rst", fe(1));
        s("decode_after_rst", de(3'b010));
        repeat (3) @(negedge clk);
        if (q.size() != 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
